// File: rtl/superpixel_draw_arbiter.sv
// superpixel_draw_arbiter: shares one superpixel draw engine between two round-robin clients and a clear-screen sweep
module superpixel_draw_arbiter #(
  parameter int SPIXEL_X_WIDTH = 6,
  parameter int SPIXEL_Y_WIDTH = 6,
  parameter logic [SPIXEL_X_WIDTH-1:0] SPIXEL_X_MAX = 6'd63,
  parameter logic [SPIXEL_Y_WIDTH-1:0] SPIXEL_Y_MAX = 6'd47,
  parameter int COLOR_ID_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic [SPIXEL_X_WIDTH-1:0] x0,
  input  logic [SPIXEL_Y_WIDTH-1:0] y0,
  input  logic [COLOR_ID_WIDTH-1:0] color0,
  output logic                      ack0,
  input  logic                      req1,
  input  logic [SPIXEL_X_WIDTH-1:0] x1,
  input  logic [SPIXEL_Y_WIDTH-1:0] y1,
  input  logic [COLOR_ID_WIDTH-1:0] color1,
  output logic                      ack1,
  input  logic                      clr_start,
  input  logic [COLOR_ID_WIDTH-1:0] clr_color,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic [SPIXEL_X_WIDTH-1:0] draw_x,
  output logic [SPIXEL_Y_WIDTH-1:0] draw_y,
  output logic [COLOR_ID_WIDTH-1:0] draw_data,
  output logic                      draw_vld,
  input  logic                      draw_done,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic last_grant_q, last_grant_d, src_q, src_d, pend_q, pend_d, run_q, run_d;
  logic [COLOR_ID_WIDTH-1:0] clr_color_q, clr_color_d, draw_data_q, draw_data_d;
  logic [SPIXEL_X_WIDTH-1:0] draw_x_q, draw_x_d;
  logic [SPIXEL_Y_WIDTH-1:0] draw_y_q, draw_y_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, clr_done_q, clr_done_d;
  logic draw_vld_q, draw_vld_d, busy_q, busy_d, clr_busy_q, clr_busy_d;
  logic r0, r1, grant1, x_end, sweep_last;
  assign r0 = req0 && !ack0_q;
  assign r1 = req1 && !ack1_q;
  assign grant1 = r1 && (!r0 || !last_grant_q);
  assign x_end = draw_x_q == SPIXEL_X_MAX;
  assign sweep_last = x_end && draw_y_q == SPIXEL_Y_MAX;
  assign {ack0, ack1, clr_done, clr_busy, busy} = {ack0_q, ack1_q, clr_done_q, clr_busy_q, busy_q};
  assign {draw_vld, draw_x, draw_y, draw_data} = {draw_vld_q, draw_x_q, draw_y_q, draw_data_q};
  // next state: sweep beats clients in IDLE; the draw operand registers double as the sweep counter
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    src_d = src_q;
    pend_d = pend_q;
    run_d = run_q;
    clr_color_d = clr_color_q;
    draw_x_d = draw_x_q;
    draw_y_d = draw_y_q;
    draw_data_d = draw_data_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    clr_done_d = 1'b0;
    if (clr_start && !pend_q && !run_q) begin
      pend_d = 1'b1;
      clr_color_d = clr_color;
    end
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          run_d = 1'b1;
          draw_x_d = '0;
          draw_y_d = '0;
          draw_data_d = clr_color_q;
          state_d = ISSUE;
        end else if (r0 || r1) begin
          src_d = grant1;
          draw_x_d = grant1 ? x1 : x0;
          draw_y_d = grant1 ? y1 : y0;
          draw_data_d = grant1 ? color1 : color0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (draw_done) begin
          if (!run_q) begin
            ack0_d = !src_q;
            ack1_d = src_q;
            last_grant_d = src_q;
            state_d = IDLE;
          end else if (!sweep_last) begin
            draw_x_d = x_end ? '0 : draw_x_q + 1'b1;
            draw_y_d = x_end ? draw_y_q + 1'b1 : draw_y_q;
            state_d = ISSUE;
          end else begin
            run_d = 1'b0;
            clr_done_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    draw_vld_d = state_d == ISSUE;
    busy_d = state_d != IDLE;
    clr_busy_d = pend_d || run_d;
  end
  // registers; reset idles everything and makes port 0 win the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      src_q <= 1'b0;
      pend_q <= 1'b0;
      run_q <= 1'b0;
      clr_color_q <= '0;
      draw_x_q <= '0;
      draw_y_q <= '0;
      draw_data_q <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      clr_done_q <= 1'b0;
      draw_vld_q <= 1'b0;
      busy_q <= 1'b0;
      clr_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      src_q <= src_d;
      pend_q <= pend_d;
      run_q <= run_d;
      clr_color_q <= clr_color_d;
      draw_x_q <= draw_x_d;
      draw_y_q <= draw_y_d;
      draw_data_q <= draw_data_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      clr_done_q <= clr_done_d;
      draw_vld_q <= draw_vld_d;
      busy_q <= busy_d;
      clr_busy_q <= clr_busy_d;
    end
  end
endmodule

// File: tb/tb_superpixel_draw_arbiter.sv
// tb_superpixel_draw_arbiter: directed and random checks of the draw arbiter against a cycle-level reference
module tb_superpixel_draw_arbiter;
  localparam int CELLS = 64 * 48;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0, clr_start = 0, draw_done = 0;
  logic [5:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
  logic [7:0] color0 = 0, color1 = 0, clr_color = 0;
  logic ack0, ack1, clr_busy, clr_done, draw_vld, busy;
  logic [5:0] draw_x, draw_y;
  logic [7:0] draw_data;
  logic [25:0] dut_o;
  int total = 0, bad = 0, cyc = 0;
  int eng_dly = 0, cnt = 0;
  bit stray_en = 0, stray_now = 0, auto_drop = 1;
  logic [19:0] vlog[$];
  int n_ack0 = 0, n_ack1 = 0, n_cd = 0, c_vld = 0, c_ack0 = 0, c_ack1 = 0, c_cd = 0;
  int m_step = 0, m_cell = -1;
  bit m_pend = 0, m_last = 1, m_src = 0, m_m0 = 0, m_m1 = 0;
  logic [7:0] m_color = 0;
  bit e_vld = 0, e_a0 = 0, e_a1 = 0, e_cd = 0, e_cb = 0, e_busy = 0;
  logic [5:0] e_x = 0, e_y = 0;
  logic [7:0] e_d = 0;

  superpixel_draw_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .y0(y0), .color0(color0), .ack0(ack0),
    .req1(req1), .x1(x1), .y1(y1), .color1(color1), .ack1(ack1),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .draw_x(draw_x), .draw_y(draw_y), .draw_data(draw_data), .draw_vld(draw_vld),
    .draw_done(draw_done), .busy(busy)
  );

  always #5 clk = ~clk;
  assign dut_o = {draw_vld, ack0, ack1, clr_done, clr_busy, busy, draw_x, draw_y, draw_data};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic put(input logic [5:0] x, input logic [5:0] y, input logic [7:0] d);
    e_x = x;
    e_y = y;
    e_d = d;
    m_step = 1;
  endtask

  // reference: m_step 0 = free to pick work, 1 = strobe cycle, 2 = command in the engine
  always @(posedge clk or negedge rst) begin : ref_model
    bit take, r0, r1;
    if (!rst) begin
      m_step = 0; m_cell = -1; m_pend = 0; m_last = 1; m_m0 = 0; m_m1 = 0;
      {e_vld, e_a0, e_a1, e_cd, e_cb, e_busy, e_x, e_y, e_d} = '0;
    end else begin
      take = clr_start && !m_pend && m_cell < 0;
      r0 = req0 && !m_m0;
      r1 = req1 && !m_m1;
      e_a0 = 0; e_a1 = 0; e_cd = 0;
      if (m_step == 0) begin
        if (m_pend) begin
          m_pend = 0;
          m_cell = 0;
          put(6'd0, 6'd0, m_color);
        end else if (r0 || r1) begin
          m_src = (r0 && r1) ? !m_last : r1;
          if (m_src) put(x1, y1, color1);
          else put(x0, y0, color0);
        end
      end else if (m_step == 1) m_step = 2;
      else if (draw_done) begin
        if (m_cell < 0) begin
          e_a0 = !m_src; e_a1 = m_src; m_last = m_src; m_step = 0;
        end else if (m_cell == CELLS - 1) begin
          m_cell = -1; e_cd = 1; m_step = 0;
        end else begin
          m_cell++;
          put(6'(m_cell % 64), 6'(m_cell / 64), m_color);
        end
      end
      if (take) begin
        m_pend = 1;
        m_color = clr_color;
      end
      m_m0 = e_a0;
      m_m1 = e_a1;
      e_vld = m_step == 1;
      e_busy = m_step != 0;
      e_cb = m_pend || m_cell >= 0;
    end
  end

  always @(posedge clk) cyc++;

  // compare every cycle outside reset
  always @(negedge clk)
    if (rst) chk("outputs", dut_o, {e_vld, e_a0, e_a1, e_cd, e_cb, e_busy, e_x, e_y, e_d});

  // engine: done after eng_dly cycles (random 1..4 when 0), plus optional stray pulses
  always @(negedge clk) begin
    draw_done = 0;
    if (!rst) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) draw_done = 1;
      end else if (stray_now || (stray_en && $urandom_range(0, 15) == 0)) draw_done = 1;
      if (draw_vld) cnt = eng_dly > 0 ? eng_dly : $urandom_range(1, 4);
    end
  end

  // event log
  always @(negedge clk) begin
    if (draw_vld) begin vlog.push_back({draw_x, draw_y, draw_data}); c_vld = cyc; end
    if (ack0) begin n_ack0++; c_ack0 = cyc; end
    if (ack1) begin n_ack1++; c_ack1 = cyc; end
    if (clr_done) begin n_cd++; c_cd = cyc; end
  end

  task automatic step();
    @(negedge clk);
    #1;
    if (auto_drop) begin
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
    end
  endtask

  function automatic int cnt_of(input int w);
    return w == 0 ? n_ack0 : w == 1 ? n_ack1 : w == 2 ? n_cd : vlog.size();
  endfunction

  task automatic wait_for(input string nm, input int w, input int target, input int budget);
    for (int n = 0; n < budget && cnt_of(w) < target; n++) step();
    chk(nm, cnt_of(w) >= target, 1);
  endtask

  initial begin
    int b, a0, a1, cd, n;
    repeat (2) step();
    chk("reset_outputs", dut_o, 0);
    rst = 1;
    step();
    // contention: both held, port 0 wins first tie
    auto_drop = 0; eng_dly = 3; b = vlog.size(); a0 = n_ack0; a1 = n_ack1;
    req0 = 1; x0 = 1; y0 = 2; color0 = 8'hAA;
    req1 = 1; x1 = 3; y1 = 4; color1 = 8'hBB;
    wait_for("cont_grants", 3, b + 4, 200);
    req0 = 0; req1 = 0; auto_drop = 1;
    for (int i = 0; i < 4; i++)
      chk("cont_order", vlog[b + i], (i % 2) ? {6'd3, 6'd4, 8'hBB} : {6'd1, 6'd2, 8'hAA});
    wait_for("cont_ack1", 1, a1 + 2, 100);
    chk("cont_ack0", n_ack0, a0 + 2);
    chk("cont_count", vlog.size() - b, 4);
    // stray done while idle
    b = vlog.size(); a0 = n_ack0; a1 = n_ack1;
    stray_now = 1; step(); stray_now = 0;
    repeat (4) step();
    chk("stray_busy", busy, 0);
    chk("stray_acks", n_ack0 + n_ack1, a0 + a1);
    chk("stray_vld", vlog.size(), b);
    // single request
    eng_dly = 10; a0 = n_ack0;
    req0 = 1; x0 = 5; y0 = 7; color0 = 8'h3C;
    step();
    chk("single_vld", draw_vld, 1);
    chk("single_cmd", {draw_x, draw_y, draw_data}, {6'd5, 6'd7, 8'h3C});
    wait_for("single_ack", 0, a0 + 1, 50);
    chk("single_latency", c_ack0 - c_vld, 11);
    repeat (5) step();
    chk("single_once", n_ack0, a0 + 1);
    // full clear sweep
    eng_dly = 1; b = vlog.size(); cd = n_cd;
    clr_start = 1; clr_color = 8'h00; step(); clr_start = 0;
    chk("clr_busy_rise", clr_busy, 1);
    chk("clr_vld_not_yet", draw_vld, 0);
    step();
    chk("clr_first", {draw_vld, draw_x, draw_y, draw_data}, {1'b1, 20'h0});
    wait_for("clr_done", 2, cd + 1, 10000);
    chk("clr_busy_end", clr_busy, 0);
    chk("clr_count", vlog.size() - b, CELLS);
    chk("clr_row0_end", vlog[b + 63], {6'd63, 6'd0, 8'h00});
    chk("clr_row1_start", vlog[b + 64], {6'd0, 6'd1, 8'h00});
    chk("clr_last", vlog[b + CELLS - 1], {6'd63, 6'd47, 8'h00});
    repeat (3) step();
    chk("clr_done_once", n_cd, cd + 1);
    // priority: sweep requested during port 1 wait with port 0 pending
    eng_dly = 10; b = vlog.size(); a0 = n_ack0;
    req1 = 1; x1 = 11; y1 = 22; color1 = 8'hC1;
    wait_for("pri_grant1", 3, b + 1, 20);
    repeat (3) step();
    clr_start = 1; clr_color = 8'h77; req0 = 1; x0 = 33; y0 = 44; color0 = 8'hC0; eng_dly = 1;
    step(); clr_start = 0;
    wait_for("pri_ack0", 0, a0 + 1, 10000);
    chk("pri_len", vlog.size() - b, CELLS + 2);
    chk("pri_first", vlog[b], {6'd11, 6'd22, 8'hC1});
    chk("pri_sweep0", vlog[b + 1], {6'd0, 6'd0, 8'h77});
    chk("pri_sweep_last", vlog[b + CELLS], {6'd63, 6'd47, 8'h77});
    chk("pri_req0", vlog[b + CELLS + 1], {6'd33, 6'd44, 8'hC0});
    chk("pri_order", (c_ack1 < c_cd) && (c_cd < c_ack0), 1);
    // reset in the middle of a sweep
    cd = n_cd;
    clr_start = 1; clr_color = 8'h55; step(); clr_start = 0;
    for (n = 0; n < 2000 && !(draw_vld && draw_x == 6'd10 && draw_y == 6'd3); n++) step();
    chk("rst_mid_cell", {draw_vld, draw_x, draw_y}, {1'b1, 6'd10, 6'd3});
    #2 rst = 0;
    #1 chk("rst_mid_outputs", dut_o, 0);
    step(); rst = 1;
    b = vlog.size(); a1 = n_ack1; eng_dly = 2;
    req1 = 1; x1 = 9; y1 = 9; color1 = 8'h5A;
    wait_for("rst_req1_ack", 1, a1 + 1, 50);
    chk("rst_req1_cmd", vlog[b], {6'd9, 6'd9, 8'h5A});
    repeat (20) step();
    chk("rst_req1_count", vlog.size() - b, 1);
    chk("rst_no_clr_done", n_cd, cd);
    chk("rst_clr_busy", clr_busy, 0);
    // random traffic
    eng_dly = 0; stray_en = 1; auto_drop = 0;
    repeat (4000) begin
      req0 = $urandom_range(0, 2) != 0;
      x0 = 6'($urandom_range(0, 63)); y0 = 6'($urandom_range(0, 63)); color0 = 8'($urandom_range(0, 255));
      req1 = $urandom_range(0, 2) != 0;
      x1 = 6'($urandom_range(0, 63)); y1 = 6'($urandom_range(0, 63)); color1 = 8'($urandom_range(0, 255));
      clr_start = $urandom_range(0, 2999) == 0; clr_color = 8'($urandom_range(0, 255));
      step();
    end
    req0 = 0; req1 = 0; clr_start = 0;
    for (n = 0; n < 20000 && !(m_step == 0 && !m_pend && m_cell < 0); n++) step();
    chk("drain_idle", m_step == 0 && !m_pend && m_cell < 0, 1);
    step();
    chk("drain_busy", {busy, clr_busy}, 0);
    stray_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/superpixel_draw_arbiter.md
# superpixel_draw_arbiter

Command scheduler in front of `draw_superpixel`. It shares the single superpixel draw engine between two client ports and a built-in clear-screen sweep. The block issues one superpixel command at a time and waits for the engine's completion pulse before issuing the next. It sits between game/overlay logic and the draw engine; the engine's RAM side is untouched.

## Interface
- `SPIXEL_X_WIDTH`, 6, superpixel column width
- `SPIXEL_Y_WIDTH`, 6, superpixel row width
- `SPIXEL_X_MAX`, 6'd63, last superpixel column
- `SPIXEL_Y_MAX`, 6'd47, last superpixel row
- `COLOR_ID_WIDTH`, 8, color index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req0` / `req1`  in  1  client request, held until ack
- `x0` / `x1`  in  SPIXEL_X_WIDTH  client superpixel column
- `y0` / `y1`  in  SPIXEL_Y_WIDTH  client superpixel row
- `color0` / `color1`  in  COLOR_ID_WIDTH  client color index
- `ack0` / `ack1`  out  1  one-cycle pulse: command fully drawn
- `clr_start`  in  1  pulse: clear whole screen
- `clr_color`  in  COLOR_ID_WIDTH  fill color, sampled with `clr_start`
- `clr_busy`  out  1  sweep pending or running
- `clr_done`  out  1  one-cycle pulse: sweep finished
- `draw_x`, `draw_y`, `draw_data`  out  engine command (to `x`, `y`, `idata`)
- `draw_vld`  out  1  one-cycle command strobe (to `idata_vld`)
- `draw_done`  in  1  engine completion pulse (from `odone`)
- `busy`  out  1  state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, in priority order:
  - If a sweep is pending: load the sweep counter to (0,0), go to ISSUE.
  - Else arbitrate between `req0` and `req1`, latch the winner's x, y and color, go to ISSUE.
  - Else stay in IDLE.
- Arbitration is round-robin on a `last_grant` bit. With a single requester, that requester wins. With both requesting, the port not granted last wins. After reset `last_grant` = 1, so port 0 wins the first tie.
- ISSUE: `draw_vld` = 1 for exactly this cycle, then go to WAIT.
- WAIT: hold until `draw_done`.
  - Client command: pulse the matching ack in the next cycle (an IDLE cycle), update `last_grant`.
  - Sweep not at (SPIXEL_X_MAX, SPIXEL_Y_MAX): advance the counter in raster order (x increments; on x == X_MAX, x wraps to 0 and y increments), go to ISSUE.
  - Sweep at the last cell: pulse `clr_done` next cycle, clear `clr_busy`, go to IDLE.
- `clr_start` seen in any state while no sweep is pending or running sets the pending flag and latches `clr_color`. `clr_busy` rises the following cycle. A `clr_start` during a sweep is ignored.
- A sweep never preempts an in-flight client command. It wins over any client request at the next IDLE.
- Client operands are latched at grant. Dropping `req` after the grant does not cancel the command. Dropping `req` before the grant withdraws it.
- In the ack cycle the acked port is masked from arbitration, so one held request never produces two commands.
- `draw_done` outside WAIT is ignored.

## Timing
- Reset (async, `rst` = 0) forces every output to 0 immediately: `draw_vld`, `draw_x`, `draw_y`, `draw_data`, `ack0`, `ack1`, `clr_busy`, `clr_done`, `busy`. It also forces state to IDLE, clears the pending sweep, and sets `last_grant` = 1. The engine must be reset by the same `rst` net.
- Request sampled in IDLE at cycle t:
  - `draw_vld` high at t+1.
  - WAIT from t+2.
  - `draw_done` seen at cycle d gives the ack at d+1.
  - A new grant is possible at d+1 for the other port, otherwise at d+2.
- `draw_x`, `draw_y` and `draw_data` are registered. They are valid in the ISSUE cycle and held until the next ISSUE.
- Sweep cell to cell: `draw_done` at d gives the next `draw_vld` at d+1. A full sweep is 64 × 48 = 3072 commands.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single request: `req0`, x0=5, y0=7, color0=8'h3C. Required: one `draw_vld` pulse one cycle later with (5,7,3C). Model `draw_done` 10 cycles later; `ack0` must pulse exactly once, the cycle after.
- Contention: `req0` and `req1` asserted together and held. Required: grants go 0,1,0,1 with correct operands each time. No double grant in an ack cycle.
- Clear: `clr_start` with `clr_color`=8'h00 from idle. Required: 3072 `draw_vld` pulses in raster order, the first (0,0), then (63,0)→(0,1), the last (63,47). `clr_busy` stays high throughout, and `clr_done` pulses once at the end.
- Priority: `clr_start` during port 1's WAIT, with `req0` pending. Required: `ack1`, then the full sweep, then the `req0` command.
- Reset mid-sweep at cell (10,3): all outputs go 0 immediately. After release, a `req1` is served normally and no `clr_done` ever appears.
- Stray `draw_done` while IDLE: no ack, no state change.
